// File: rtl/micro_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : micro_seq_pkg
//  Purpose  : Shared definitions for the micro_sequencer block. Holds the
//             branch-op encodings, the sequencer state encoding and helpers
//             that locate each field of a microcode word.
//  Contents : OP_* op encodings, state_e, field offset helpers
//  Revision : 1.0 - initial release
// ============================================================================
package micro_seq_pkg;

  // Branch-field encodings. Codes 8..15 are illegal.
  localparam logic [3:0] OP_NEXT = 4'd0;
  localparam logic [3:0] OP_JMP  = 4'd1;
  localparam logic [3:0] OP_JC   = 4'd2;
  localparam logic [3:0] OP_JNC  = 4'd3;
  localparam logic [3:0] OP_WAIT = 4'd4;
  localparam logic [3:0] OP_CALL = 4'd5;
  localparam logic [3:0] OP_RET  = 4'd6;
  localparam logic [3:0] OP_HALT = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WAIT  = 2'd3
  } state_e;

  // Word layout, MSB first: op(4) | target(A) | csel(4) | ctrl(rest).
  function automatic int op_lsb(input int d_width);
    return d_width - 4;
  endfunction

  function automatic int target_lsb(input int a_width, input int d_width);
    return d_width - 4 - a_width;
  endfunction

  function automatic int csel_lsb(input int a_width, input int d_width);
    return d_width - 8 - a_width;
  endfunction

  function automatic int ctrl_width(input int a_width, input int d_width);
    return d_width - 8 - a_width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/micro_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : micro_sequencer_if
//  Purpose  : Bus between the sequencer and the synchronous microcode ROM.
//  Ports    : rom_addr (seq->ROM), rom_re (seq->ROM),
//             rom_data (ROM->seq, valid the cycle after rom_re)
//  Modports : master = sequencer side, slave = ROM side
//  Revision : 1.0 - initial release
// ============================================================================
interface micro_sequencer_if
  import micro_seq_pkg::*;
#(
  parameter int A_WIDTH = 4,
  parameter int D_WIDTH = 48
);
  logic [A_WIDTH-1:0] rom_addr;
  logic               rom_re;
  logic [D_WIDTH-1:0] rom_data;

  modport master (output rom_addr, output rom_re, input  rom_data);
  modport slave  (input  rom_addr, input  rom_re, output rom_data);
endinterface
`default_nettype wire

// File: rtl/micro_seq_stack.sv
`default_nettype none
// ============================================================================
//  Module   : micro_seq_stack
//  Purpose  : Return-address LIFO for CALL/RET. Push while full and pop
//             while empty are ignored; the caller flags the error.
//  Ports    : clk, rst_n (async, active low), push, pop, clear (sync,
//             wipes pointer and contents), push_data, top_data (entry a pop
//             would return), full, empty
//  Revision : 1.0 - initial release
// ============================================================================
module micro_seq_stack
  import micro_seq_pkg::*;
#(
  parameter int A_WIDTH     = 4,
  parameter int STACK_DEPTH = 4
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  input  wire logic               push,
  input  wire logic               pop,
  input  wire logic               clear,
  input  wire logic [A_WIDTH-1:0] push_data,
  output logic      [A_WIDTH-1:0] top_data,
  output logic                    full,
  output logic                    empty
);
  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);

  logic [SP_W-1:0]    sp_q, sp_d;
  logic [A_WIDTH-1:0] mem_q [STACK_DEPTH];
  logic [A_WIDTH-1:0] mem_d [STACK_DEPTH];
  logic [IDX_W-1:0]   wr_idx, rd_idx;

  // With a power-of-two depth the low pointer bits are the write slot; the
  // slot below wraps correctly even when sp == STACK_DEPTH.
  assign wr_idx   = sp_q[IDX_W-1:0];
  assign rd_idx   = wr_idx - 1'b1;
  assign top_data = mem_q[rd_idx];
  assign full     = (sp_q == SP_W'(STACK_DEPTH));
  assign empty    = (sp_q == '0);

  always_comb begin
    sp_d  = sp_q;
    mem_d = mem_q;
    if (clear) begin
      sp_d = '0;
      for (int i = 0; i < STACK_DEPTH; i++) mem_d[i] = '0;
    end else if (push && !full) begin
      mem_d[wr_idx] = push_data;
      sp_d          = sp_q + 1'b1;
    end else if (pop && !empty) begin
      sp_d = sp_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      sp_q  <= sp_d;
      mem_q <= mem_d;
    end
  end
endmodule
`default_nettype wire

// File: rtl/micro_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : micro_sequencer
//  Purpose  : Microprogram sequencer in front of a synchronous microcode ROM.
//             Fetches a word, decodes its branch op, computes the next
//             address and issues the control field as a registered word
//             with a one-cycle strobe.
//  Ports    : clk, rst_n (async, active low), start/start_addr, abort,
//             cond_in[15:0], rom_if (master: rom_addr, rom_re, rom_data),
//             ctrl_out, ctrl_strobe, pc_out, busy, done, error (sticky)
//  Revision : 1.0 - initial release
// ============================================================================
module micro_sequencer
  import micro_seq_pkg::*;
#(
  parameter  int A_WIDTH     = 4,
  parameter  int D_WIDTH     = 48,
  parameter  int STACK_DEPTH = 4,
  localparam int CTRL_WIDTH  = ctrl_width(A_WIDTH, D_WIDTH)
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic                  start,
  input  wire logic [A_WIDTH-1:0]    start_addr,
  input  wire logic                  abort,
  input  wire logic [15:0]           cond_in,
  micro_sequencer_if.master          rom_if,
  output logic      [CTRL_WIDTH-1:0] ctrl_out,
  output logic                       ctrl_strobe,
  output logic      [A_WIDTH-1:0]    pc_out,
  output logic                       busy,
  output logic                       done,
  output logic                       error
);
  localparam int OP_LSB   = op_lsb(D_WIDTH);
  localparam int TGT_LSB  = target_lsb(A_WIDTH, D_WIDTH);
  localparam int CSEL_LSB = csel_lsb(A_WIDTH, D_WIDTH);

  state_e                state_q, state_d;
  logic [A_WIDTH-1:0]    pc_q, pc_d, rom_addr_q, rom_addr_d, pc_out_q, pc_out_d;
  logic                  rom_re_q, rom_re_d, strobe_q, strobe_d;
  logic                  halt_q, halt_d, done_q, error_q, error_d;
  logic [CTRL_WIDTH-1:0] ctrl_q, ctrl_d, wait_ctrl_q, wait_ctrl_d;
  logic [3:0]            wait_csel_q, wait_csel_d;

  logic [3:0]            op, op_csel;
  logic [A_WIDTH-1:0]    op_target, pc_inc, next_pc, stack_top;
  logic [CTRL_WIDTH-1:0] op_ctrl, strobe_ctrl;
  logic                  cond_bit, fetch_en, strobe_en;
  logic                  push, pop, clear, full, empty;

  assign op        = rom_if.rom_data[OP_LSB +: 4];
  assign op_target = rom_if.rom_data[TGT_LSB +: A_WIDTH];
  assign op_csel   = rom_if.rom_data[CSEL_LSB +: 4];
  assign op_ctrl   = rom_if.rom_data[CTRL_WIDTH-1:0];
  assign cond_bit  = cond_in[op_csel];
  assign pc_inc    = pc_q + 1'b1;

  micro_seq_stack #(
    .A_WIDTH    (A_WIDTH),
    .STACK_DEPTH(STACK_DEPTH)
  ) u_stack (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (pop),
    .clear    (clear),
    .push_data(pc_inc),
    .top_data (stack_top),
    .full     (full),
    .empty    (empty)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    rom_addr_d  = rom_addr_q;
    rom_re_d    = 1'b0;
    ctrl_d      = ctrl_q;
    pc_out_d    = pc_out_q;
    strobe_d    = 1'b0;
    halt_d      = 1'b0;
    error_d     = error_q;
    wait_ctrl_d = wait_ctrl_q;
    wait_csel_d = wait_csel_q;
    push        = 1'b0;
    pop         = 1'b0;
    clear       = 1'b0;
    fetch_en    = 1'b0;
    strobe_en   = 1'b0;
    next_pc     = pc_inc;
    strobe_ctrl = op_ctrl;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          error_d  = 1'b0;
          clear    = 1'b1;
          next_pc  = start_addr;
          fetch_en = 1'b1;
        end
      end
      ST_FETCH: state_d = abort ? ST_IDLE : ST_EXEC;
      ST_EXEC: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          case (op)
            OP_NEXT: begin fetch_en = 1'b1; strobe_en = 1'b1; end
            OP_JMP:  begin next_pc = op_target; fetch_en = 1'b1; strobe_en = 1'b1; end
            OP_JC: begin
              if (cond_bit) next_pc = op_target;
              fetch_en  = 1'b1;
              strobe_en = 1'b1;
            end
            OP_JNC: begin
              if (!cond_bit) next_pc = op_target;
              fetch_en  = 1'b1;
              strobe_en = 1'b1;
            end
            // The control word is held back until the wait condition fires.
            OP_WAIT: begin
              wait_ctrl_d = op_ctrl;
              wait_csel_d = op_csel;
              state_d     = ST_WAIT;
            end
            OP_CALL: begin
              if (full) begin
                error_d = 1'b1;
                state_d = ST_IDLE;
              end else begin
                push      = 1'b1;
                next_pc   = op_target;
                fetch_en  = 1'b1;
                strobe_en = 1'b1;
              end
            end
            OP_RET: begin
              if (empty) begin
                error_d = 1'b1;
                state_d = ST_IDLE;
              end else begin
                pop       = 1'b1;
                next_pc   = stack_top;
                fetch_en  = 1'b1;
                strobe_en = 1'b1;
              end
            end
            OP_HALT: begin
              strobe_en = 1'b1;
              halt_d    = 1'b1;
              state_d   = ST_IDLE;
            end
            default: begin
              error_d = 1'b1;
              state_d = ST_IDLE;
            end
          endcase
        end
      end
      ST_WAIT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (cond_in[wait_csel_q]) begin
          strobe_ctrl = wait_ctrl_q;
          fetch_en    = 1'b1;
          strobe_en   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // rom_re is registered, so it is raised on entry to FETCH and lasts
    // exactly that one cycle.
    if (fetch_en) begin
      pc_d       = next_pc;
      rom_addr_d = next_pc;
      rom_re_d   = 1'b1;
      state_d    = ST_FETCH;
    end
    if (strobe_en) begin
      ctrl_d   = strobe_ctrl;
      pc_out_d = pc_q;
      strobe_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      rom_addr_q  <= '0;
      rom_re_q    <= 1'b0;
      ctrl_q      <= '0;
      pc_out_q    <= '0;
      strobe_q    <= 1'b0;
      halt_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      wait_ctrl_q <= '0;
      wait_csel_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      rom_addr_q  <= rom_addr_d;
      rom_re_q    <= rom_re_d;
      ctrl_q      <= ctrl_d;
      pc_out_q    <= pc_out_d;
      strobe_q    <= strobe_d;
      halt_q      <= halt_d;
      // done follows the HALT strobe by one cycle.
      done_q      <= halt_q;
      error_q     <= error_d;
      wait_ctrl_q <= wait_ctrl_d;
      wait_csel_q <= wait_csel_d;
    end
  end

  assign rom_if.rom_addr = rom_addr_q;
  assign rom_if.rom_re   = rom_re_q;
  assign ctrl_out        = ctrl_q;
  assign ctrl_strobe     = strobe_q;
  assign pc_out          = pc_out_q;
  assign busy            = (state_q != ST_IDLE);
  assign done            = done_q;
  assign error           = error_q;
endmodule
`default_nettype wire
